// File: rtl/serial_mult_pkg.sv
// Shared definitions for the serial shift-add multiplier controller.
// State encodings are plain constants so older flows can consume them unchanged.
package serial_mult_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned N_MIN = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_RUN  = 3'd2;
    localparam state_t ST_LAST = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/serial_mult_fsm.sv
// Sequencer for the serial multiplier: state, watchdog and the counter handshake.
// All outputs except the accept strobe are registered or decoded from state.
module serial_mult_fsm
    import serial_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_i,
    input  logic             n_equal_i,
    output logic             accept_o,
    output logic             clear_o,
    output logic             iterate_o,
    output logic             init_count_o,
    output logic             en_count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic [31:0]      n_ext;
    logic             n_legal;

    assign n_ext   = 32'(n_i);
    assign n_legal = (n_ext >= N_MIN) && (n_ext <= WIDTH);

    always_comb begin
        state_d = state_q;
        wd_d    = '0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (n_legal) begin
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                wd_d = wd_q + 1'b1;
                // Watchdog: sixteen RUN cycles without nEqual means the counter has wrapped.
                if (n_equal_i || (wd_q == '1)) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        accept_o     = (state_q == ST_IDLE) && start_i && n_legal;
        clear_o      = (state_q == ST_LOAD);
        iterate_o    = (state_q == ST_RUN) || (state_q == ST_LAST);
        init_count_o = (state_q == ST_LOAD);
        en_count_o   = (state_q == ST_RUN);
        busy_o       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_LAST);
        done_o       = (state_q == ST_DONE);
        err_o        = err_q;
    end

endmodule

// File: rtl/serial_mult_ctrl.sv
// Serial shift-add multiplier: operand/product datapath around the sequencer.
// Drives an external iteration counter and uses its nEqual flag to end the run.
module serial_mult_ctrl
    import serial_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [CNT_W-1:0]     nIn,
    input  logic                 nEqual,
    output logic                 initCount,
    output logic                 enCount,
    output logic [CNT_W-1:0]     NregOut,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   product
);

    logic                 accept;
    logic                 clear;
    logic                 iterate;
    logic [WIDTH-1:0]     mask;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     n_q, n_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    serial_mult_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .clk_i        (clk),
        .rst_ni       (rst),
        .start_i      (start),
        .n_i          (nIn),
        .n_equal_i    (nEqual),
        .accept_o     (accept),
        .clear_o      (clear),
        .iterate_o    (iterate),
        .init_count_o (initCount),
        .en_count_o   (enCount),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    // Keep only the low N operand bits.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            mask[i] = (i < int'(nIn));
        end
    end

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        n_d       = n_q;
        product_d = product_q;
        if (accept) begin
            mcand_d  = {{WIDTH{1'b0}}, a & mask};
            mplier_d = b & mask;
            n_d      = nIn;
        end else if (iterate) begin
            if (mplier_q[0]) begin
                product_d = product_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
        if (clear) begin
            product_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            n_q       <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            n_q       <= n_d;
            product_q <= product_d;
        end
    end

    assign NregOut = n_q;
    assign product = product_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed bench for serial_mult_ctrl with a behavioural iteration counter beside it.
// Expected products and timing are queued at start and compared when done appears.
module tb_serial_mult_ctrl;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a_s;
    logic [WIDTH-1:0]   b_s;
    logic [3:0]         n_s;
    logic               nEqual;
    logic               initCount;
    logic               enCount;
    logic [3:0]         NregOut;
    logic               busy;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] product;

    logic [3:0]         cnt;
    logic               stuck;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          en;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    serial_mult_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a_s),
        .b         (b_s),
        .nIn       (n_s),
        .nEqual    (nEqual),
        .initCount (initCount),
        .enCount   (enCount),
        .NregOut   (NregOut),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural nCounter; stuck models a broken counter that never flags.
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 4'd0;
        else if (initCount) cnt <= 4'd0;
        else if (enCount) cnt <= cnt + 4'd1;
    end
    assign nEqual = !stuck && (cnt == (NregOut - 4'd2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input int n,
                            input bit wd);
        exp_t        e;
        logic [15:0] m;
        m      = (16'h1 << n) - 16'h1;
        e.prod = (16'(av) & m) * (16'(bv) & m);
        e.lat  = wd ? 19 : n + 2;
        e.en   = wd ? 16 : n - 1;
        sb.push_back(e);
        @(negedge clk);
        a_s   = av;
        b_s   = bv;
        n_s   = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit intrude);
        exp_t e;
        int   k  = 1;
        int   en = 0;
        bit   both = 0;
        check("busy_in_load", busy, 1);
        check("init_in_load", initCount, 1);
        while (!done && k < 64) begin
            if (enCount) en++;
            if (enCount && initCount) both = 1;
            if (intrude && k == 3) begin
                a_s   = 8'hFF;
                b_s   = 8'hFF;
                n_s   = 4'd8;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 1);
        e = sb.pop_front();
        check("product", product, e.prod);
        check("latency", k, e.lat);
        check("encount_cycles", en, e.en);
        check("init_en_exclusive", both, 0);
        check("busy_in_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] prev_p;
        logic [3:0]  prev_n;
        int          seen_done;
        int          bad_n[3] = '{1, 0, 9};

        rst   = 1'b0;
        start = 1'b0;
        stuck = 1'b0;
        a_s   = '0;
        b_s   = '0;
        n_s   = '0;
        repeat (2) @(negedge clk);
        check("rst_product", product, 0);
        check("rst_nreg", NregOut, 0);
        check("rst_flags", {busy, done, err, initCount, enCount}, 0);
        rst = 1'b1;
        @(negedge clk);

        start_op(8'hFF, 8'hFF, 8, 0);
        run_to_done(0);
        start_op(8'hAB, 8'h37, 4, 0);
        run_to_done(0);
        start_op(8'h03, 8'h03, 2, 0);
        run_to_done(0);
        start_op(8'h80, 8'h80, 8, 0);
        run_to_done(0);

        for (int i = 0; i < 3; i++) begin
            prev_p = product;
            prev_n = NregOut;
            @(negedge clk);
            a_s   = 8'h11;
            b_s   = 8'h22;
            n_s   = 4'(bad_n[i]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            @(negedge clk);
            check("err_clears", err, 0);
            check("err_busy2", busy, 0);
            check("err_product_held", product, prev_p);
            check("err_nreg_held", NregOut, prev_n);
        end

        start_op(8'h12, 8'h34, 8, 0);
        run_to_done(1);

        stuck = 1'b1;
        start_op(8'h9C, 8'h05, 8, 1);
        run_to_done(0);
        stuck = 1'b0;

        start_op(8'h5A, 8'h3C, 8, 0);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_en", enCount, 0);
        check("async_rst_product", product, 0);
        check("async_rst_done", done, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("no_activity_after_reset", seen_done, 0);
        check("product_after_reset", product, 0);

        start_op(8'h0D, 8'h0E, 5, 0);
        run_to_done(0);

        for (int i = 0; i < 4; i++) begin
            start_op(8'($urandom), 8'($urandom), int'($urandom_range(2, 8)), 0);
            run_to_done(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_mult_ctrl.md
# serial_mult_ctrl

Sequencer and shift-add datapath for an N-iteration serial multiplier, N selected per operation (2..WIDTH). Sits directly upstream of the iteration counter (`nCounter`): it drives the counter's `initCount`, `enCount` and `NregIn` inputs and consumes its `nEqual` flag to decide when the final iteration is due. It accepts a start request with two operands and returns the product of the low N bits of each operand, with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: maximum operand width. Legal range is 2..15, because N is carried in 4 bits.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset. The block is in reset while `rst` = 0.
- `start`: input, 1 bit. Operation request; sampled only in IDLE.
- `a`: input, WIDTH bits. Multiplicand; sampled with `start`.
- `b`: input, WIDTH bits. Multiplier; sampled with `start`.
- `nIn`: input, 4 bits. Iteration count N; sampled with `start`.
- `nEqual`: input, 1 bit. From the counter. Counter semantics: the count clears on `initCount` and increments on `enCount`. `nEqual` = 1 exactly when count == `NregOut` − 2 (4-bit wrap).
- `initCount`: output, 1 bit. Counter clear.
- `enCount`: output, 1 bit. Counter increment.
- `NregOut`: output, 4 bits. Latched N, fed to the counter's `NregIn`.
- `busy`: output, 1 bit. High in LOAD, RUN and LAST.
- `done`: output, 1 bit. One-cycle pulse when `product` becomes valid.
- `err`: output, 1 bit. One-cycle pulse when a start is rejected.
- `product`: output, 2·WIDTH bits. Result; held until the next accepted start.

## Operation
- The FSM is Moore with states IDLE, LOAD, RUN, LAST, DONE. All outputs are registered or decoded from state only.
- **IDLE**
  - `start` with 2 ≤ `nIn` ≤ WIDTH is accepted:
    - `mcand` ← `a` masked to N bits, zero-extended to 2·WIDTH.
    - `mplier` ← `b` masked to N bits.
    - `NregOut` ← `nIn`.
    - Next state LOAD.
  - `start` with an illegal `nIn`: `err` = 1 in the next cycle, state remains IDLE, and no register other than `err` changes.
- **LOAD**
  - `initCount` = 1 and `product` ← 0.
  - Next state RUN.
- **RUN**
  - `enCount` = 1.
  - One iteration per cycle:
    - If `mplier[0]` = 1, `product` ← `product` + `mcand` (modulo 2·WIDTH; no overflow is possible).
    - `mcand` ← `mcand` << 1.
    - `mplier` ← `mplier` >> 1.
  - If `nEqual` = 1, next state LAST; otherwise stay in RUN.
- **LAST**
  - Performs the same iteration as RUN, with `enCount` = 0.
  - Next state DONE.
  - Total iterations are N: (N−1) in RUN plus 1 in LAST.
- **DONE**
  - `done` = 1 and `product` is final.
  - Next state IDLE.
  - A `start` seen in DONE is ignored.
- A `start` in LOAD, RUN or LAST is ignored: no queuing and no `err`.
- Result: `product` = (`a` mod 2^N) · (`b` mod 2^N), which occupies at most 2N bits.
- `initCount` and `enCount` are never both high.

## Timing
- Reset (`rst` = 0) values:
  - state = IDLE.
  - `product`, `mcand`, `mplier` = 0.
  - `NregOut` = 0.
  - `busy`, `done`, `err`, `initCount`, `enCount` = 0.
- Reset mid-operation aborts immediately and asynchronously. On release the block is in IDLE with `product` = 0. No `done` pulse is produced.
- Latency for a start sampled at edge t:
  - LOAD during cycle t+1.
  - RUN during cycles t+2 … t+N.
  - LAST during cycle t+N+1.
  - `done` high during cycle t+N+2.
- Throughput: the earliest next accepted start is sampled at the edge that ends DONE, i.e. one operation per N+3 cycles.
- Boundary case N = 2: `nEqual` is already 1 in the first RUN cycle (count 0). Sequence is RUN for 1 cycle, then LAST, then DONE.
- Boundary case N = WIDTH: `mcand` reaches bit 2·WIDTH−2 and never overflows.
- If `nEqual` stays low for 16 RUN cycles (the counter has wrapped, indicating a broken counter), the FSM forces LAST. A 4-bit watchdog counter, internal to this block, enforces this.

## Structure
- A shared package holds:
  - the state enum (IDLE, LOAD, RUN, LAST, DONE);
  - `N_MIN` = 2;
  - the 4-bit count width constant.
- One sub-module is natural: `serial_mult_fsm`. It owns state, the watchdog, `initCount`, `enCount`, `busy`, `done` and `err`.
- The top level owns the operand and product registers.
- `nCounter` is instantiated beside this block, not inside it.

## Test plan
- **Basic multiply.** WIDTH=8, `a`=0xFF, `b`=0xFF, `nIn`=8 → `done` 10 cycles after the start edge, `product`=0xFE01; `enCount` high for exactly 7 cycles.
- **Masking.** `a`=0xAB, `b`=0x37, `nIn`=4 → masked operands 0xB, 0x7 → `product`=0x004D after 6 cycles.
- **Minimum N.** `nIn`=2, `a`=3, `b`=3 → `product`=9; RUN lasts exactly 1 cycle.
- **Illegal N.** `nIn`=1, 0 and 9 (with WIDTH=8), each with `start` → `err` pulses one cycle each, `busy` stays 0, `product` unchanged.
- **Start while busy.** Assert `start` with new operands during RUN → ignored; the original result is delivered; the next start is accepted only from IDLE.
- **Reset mid-operation.** Drive `rst` low during RUN → all outputs 0 immediately, no `done` pulse; a new start after release completes correctly.
